rv32_instr_writer: RTL

Streaming RV32I instruction encoder and instruction-memory loader: accepts symbolic instructions (opcode enum, register indices, immediate) over a valid/ready stream, encodes each into the 32-bit RV32I word that `rv32_decoder` maps back to the same `rv32_opcode_enum_t`, and writes it to consecutive instruction-memory word addresses. Sits between the testbench/debug program loader and the core's instruction memory write port; also used to generate directed instruction streams for decoder and core regression.

---
 rtl/rv32_instr_writer_pkg.sv | 88 ++++++++
 rtl/rv32_instr_encoder.sv | 112 +++++++++++
 rtl/rv32_instr_writer.sv | 103 ++++++++++
 3 files changed

// File: rtl/rv32_instr_writer_pkg.sv
// Shared RV32I definitions for the instruction writer: opcode enum, error codes,
// major opcode and funct constants, and immediate range helpers.
package rv32_instr_writer_pkg;

  typedef enum logic [5:0] {
    RV32_UNKNOWN = 6'd0,
    RV32_LUI, RV32_AUIPC, RV32_JAL, RV32_JALR,
    RV32_BEQ, RV32_BNE, RV32_BLT, RV32_BGE, RV32_BLTU, RV32_BGEU,
    RV32_LB, RV32_LH, RV32_LW, RV32_LBU, RV32_LHU,
    RV32_SB, RV32_SH, RV32_SW,
    RV32_ADDI, RV32_SLTI, RV32_SLTIU, RV32_XORI, RV32_ORI, RV32_ANDI,
    RV32_SLLI, RV32_SRLI, RV32_SRAI,
    RV32_ADD, RV32_SUB, RV32_SLL, RV32_SLT, RV32_SLTU,
    RV32_XOR, RV32_SRL, RV32_SRA, RV32_OR, RV32_AND,
    RV32_FENCE, RV32_ECALL, RV32_EBREAK,
    RV32_CSRRW, RV32_CSRRS, RV32_CSRRC, RV32_CSRRWI, RV32_CSRRSI, RV32_CSRRCI
  } rv32_opcode_enum_t;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_UNKNOWN   = 2'd1,
    ERR_IMM_RANGE = 2'd2,
    ERR_FULL      = 2'd3
  } rv32_err_code_t;

  typedef enum logic [1:0] {
    WR_IDLE  = 2'd0,
    WR_LOAD  = 2'd1,
    WR_DONE  = 2'd2,
    WR_ERROR = 2'd3
  } writer_state_t;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} rv32_fmt_t;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_S12, IMM_B13, IMM_J21, IMM_UPPER, IMM_SHAMT, IMM_CSR
  } rv32_imm_rule_t;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  localparam logic [2:0] F3_ADD_SUB = 3'd0;
  localparam logic [2:0] F3_SLL     = 3'd1;
  localparam logic [2:0] F3_SLT     = 3'd2;
  localparam logic [2:0] F3_SLTU    = 3'd3;
  localparam logic [2:0] F3_XOR     = 3'd4;
  localparam logic [2:0] F3_SRL_SRA = 3'd5;
  localparam logic [2:0] F3_OR      = 3'd6;
  localparam logic [2:0] F3_AND     = 3'd7;
  localparam logic [2:0] F3_BEQ     = 3'd0;
  localparam logic [2:0] F3_BNE     = 3'd1;
  localparam logic [2:0] F3_BLT     = 3'd4;
  localparam logic [2:0] F3_BGE     = 3'd5;
  localparam logic [2:0] F3_BLTU    = 3'd6;
  localparam logic [2:0] F3_BGEU    = 3'd7;
  localparam logic [2:0] F3_B       = 3'd0;
  localparam logic [2:0] F3_H       = 3'd1;
  localparam logic [2:0] F3_W       = 3'd2;
  localparam logic [2:0] F3_BU      = 3'd4;
  localparam logic [2:0] F3_HU      = 3'd5;
  localparam logic [2:0] F3_PRIV    = 3'd0;
  localparam logic [2:0] F3_CSRRW   = 3'd1;
  localparam logic [2:0] F3_CSRRS   = 3'd2;
  localparam logic [2:0] F3_CSRRC   = 3'd3;
  localparam logic [2:0] F3_CSRRWI  = 3'd5;
  localparam logic [2:0] F3_CSRRSI  = 3'd6;
  localparam logic [2:0] F3_CSRRCI  = 3'd7;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // True when imm is representable as a two's-complement value of the given width.
  function automatic logic imm_fits_signed(input logic [31:0] imm, input int unsigned bits);
    logic signed [31:0] s;
    s = $signed(imm) >>> (bits - 1);
    return (s == '0) || (s == '1);
  endfunction

endpackage

// File: rtl/rv32_instr_encoder.sv
// Combinational RV32I encoder: symbolic instruction -> 32-bit word, plus legality
// and immediate-range flags for the writer's checks.
module rv32_instr_encoder
  import rv32_instr_writer_pkg::*;
(
  input  rv32_opcode_enum_t opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  output logic [31:0]       word,
  output logic              legal,
  output logic              imm_ok
);

  rv32_fmt_t      fmt;
  rv32_imm_rule_t rule;
  logic [6:0]     major;
  logic [2:0]     f3;
  logic [6:0]     f7;
  logic [11:0]    imm12;
  logic [4:0]     rd_f;
  logic [4:0]     rs1_f;

  always_comb begin
    fmt   = FMT_R;
    rule  = IMM_NONE;
    major = OPC_OP;
    f3    = 3'd0;
    f7    = F7_BASE;
    imm12 = imm[11:0];
    rd_f  = rd;
    rs1_f = rs1;
    legal = 1'b1;

    case (opcode)
      RV32_LUI:    begin fmt = FMT_U; rule = IMM_UPPER; major = OPC_LUI; end
      RV32_AUIPC:  begin fmt = FMT_U; rule = IMM_UPPER; major = OPC_AUIPC; end
      RV32_JAL:    begin fmt = FMT_J; rule = IMM_J21; major = OPC_JAL; end
      RV32_JALR:   begin fmt = FMT_I; rule = IMM_S12; major = OPC_JALR; end
      RV32_BEQ:    begin fmt = FMT_B; rule = IMM_B13; major = OPC_BRANCH; f3 = F3_BEQ; end
      RV32_BNE:    begin fmt = FMT_B; rule = IMM_B13; major = OPC_BRANCH; f3 = F3_BNE; end
      RV32_BLT:    begin fmt = FMT_B; rule = IMM_B13; major = OPC_BRANCH; f3 = F3_BLT; end
      RV32_BGE:    begin fmt = FMT_B; rule = IMM_B13; major = OPC_BRANCH; f3 = F3_BGE; end
      RV32_BLTU:   begin fmt = FMT_B; rule = IMM_B13; major = OPC_BRANCH; f3 = F3_BLTU; end
      RV32_BGEU:   begin fmt = FMT_B; rule = IMM_B13; major = OPC_BRANCH; f3 = F3_BGEU; end
      RV32_LB:     begin fmt = FMT_I; rule = IMM_S12; major = OPC_LOAD; f3 = F3_B; end
      RV32_LH:     begin fmt = FMT_I; rule = IMM_S12; major = OPC_LOAD; f3 = F3_H; end
      RV32_LW:     begin fmt = FMT_I; rule = IMM_S12; major = OPC_LOAD; f3 = F3_W; end
      RV32_LBU:    begin fmt = FMT_I; rule = IMM_S12; major = OPC_LOAD; f3 = F3_BU; end
      RV32_LHU:    begin fmt = FMT_I; rule = IMM_S12; major = OPC_LOAD; f3 = F3_HU; end
      RV32_SB:     begin fmt = FMT_S; rule = IMM_S12; major = OPC_STORE; f3 = F3_B; end
      RV32_SH:     begin fmt = FMT_S; rule = IMM_S12; major = OPC_STORE; f3 = F3_H; end
      RV32_SW:     begin fmt = FMT_S; rule = IMM_S12; major = OPC_STORE; f3 = F3_W; end
      RV32_ADDI:   begin fmt = FMT_I; rule = IMM_S12; major = OPC_OP_IMM; f3 = F3_ADD_SUB; end
      RV32_SLTI:   begin fmt = FMT_I; rule = IMM_S12; major = OPC_OP_IMM; f3 = F3_SLT; end
      RV32_SLTIU:  begin fmt = FMT_I; rule = IMM_S12; major = OPC_OP_IMM; f3 = F3_SLTU; end
      RV32_XORI:   begin fmt = FMT_I; rule = IMM_S12; major = OPC_OP_IMM; f3 = F3_XOR; end
      RV32_ORI:    begin fmt = FMT_I; rule = IMM_S12; major = OPC_OP_IMM; f3 = F3_OR; end
      RV32_ANDI:   begin fmt = FMT_I; rule = IMM_S12; major = OPC_OP_IMM; f3 = F3_AND; end
      // Shift-immediates carry funct7 in imm[11:5] of the I-type slot.
      RV32_SLLI:   begin fmt = FMT_I; rule = IMM_SHAMT; major = OPC_OP_IMM; f3 = F3_SLL;
                         imm12 = {F7_BASE, imm[4:0]}; end
      RV32_SRLI:   begin fmt = FMT_I; rule = IMM_SHAMT; major = OPC_OP_IMM; f3 = F3_SRL_SRA;
                         imm12 = {F7_BASE, imm[4:0]}; end
      RV32_SRAI:   begin fmt = FMT_I; rule = IMM_SHAMT; major = OPC_OP_IMM; f3 = F3_SRL_SRA;
                         imm12 = {F7_ALT, imm[4:0]}; end
      RV32_ADD:    begin f3 = F3_ADD_SUB; end
      RV32_SUB:    begin f3 = F3_ADD_SUB; f7 = F7_ALT; end
      RV32_SLL:    begin f3 = F3_SLL; end
      RV32_SLT:    begin f3 = F3_SLT; end
      RV32_SLTU:   begin f3 = F3_SLTU; end
      RV32_XOR:    begin f3 = F3_XOR; end
      RV32_SRL:    begin f3 = F3_SRL_SRA; end
      RV32_SRA:    begin f3 = F3_SRL_SRA; f7 = F7_ALT; end
      RV32_OR:     begin f3 = F3_OR; end
      RV32_AND:    begin f3 = F3_AND; end
      RV32_FENCE:  begin fmt = FMT_I; rule = IMM_S12; major = OPC_MISC_MEM; end
      RV32_ECALL:  begin fmt = FMT_I; major = OPC_SYSTEM; f3 = F3_PRIV;
                         imm12 = 12'd0; rd_f = 5'd0; rs1_f = 5'd0; end
      RV32_EBREAK: begin fmt = FMT_I; major = OPC_SYSTEM; f3 = F3_PRIV;
                         imm12 = 12'd1; rd_f = 5'd0; rs1_f = 5'd0; end
      RV32_CSRRW:  begin fmt = FMT_I; rule = IMM_CSR; major = OPC_SYSTEM; f3 = F3_CSRRW; end
      RV32_CSRRS:  begin fmt = FMT_I; rule = IMM_CSR; major = OPC_SYSTEM; f3 = F3_CSRRS; end
      RV32_CSRRC:  begin fmt = FMT_I; rule = IMM_CSR; major = OPC_SYSTEM; f3 = F3_CSRRC; end
      RV32_CSRRWI: begin fmt = FMT_I; rule = IMM_CSR; major = OPC_SYSTEM; f3 = F3_CSRRWI; end
      RV32_CSRRSI: begin fmt = FMT_I; rule = IMM_CSR; major = OPC_SYSTEM; f3 = F3_CSRRSI; end
      RV32_CSRRCI: begin fmt = FMT_I; rule = IMM_CSR; major = OPC_SYSTEM; f3 = F3_CSRRCI; end
      default:     legal = 1'b0;
    endcase

    case (rule)
      IMM_S12:   imm_ok = imm_fits_signed(imm, 12);
      IMM_B13:   imm_ok = imm_fits_signed(imm, 13) && !imm[0];
      IMM_J21:   imm_ok = imm_fits_signed(imm, 21) && !imm[0];
      IMM_UPPER: imm_ok = (imm[11:0] == 12'd0);
      IMM_SHAMT: imm_ok = (imm[31:5] == 27'd0);
      IMM_CSR:   imm_ok = (imm[31:12] == 20'd0);
      default:   imm_ok = 1'b1;
    endcase

    case (fmt)
      FMT_I:   word = {imm12, rs1_f, f3, rd_f, major};
      FMT_S:   word = {imm[11:5], rs2, rs1, f3, imm[4:0], major};
      FMT_B:   word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], major};
      FMT_U:   word = {imm[31:12], rd, major};
      FMT_J:   word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, major};
      default: word = {f7, rs2, rs1_f, f3, rd_f, major};
    endcase
  end

endmodule

// File: rtl/rv32_instr_writer.sv
// Streaming RV32I encoder and instruction-memory loader. Encodes each accepted
// instruction and writes it one cycle later to consecutive word addresses.
module rv32_instr_writer
  import rv32_instr_writer_pkg::*;
#(
  parameter int IMEM_ADDR_W = 12,
  parameter int BASE_ADDR   = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  rv32_opcode_enum_t      in_opcode,
  input  logic [4:0]             in_rd,
  input  logic [4:0]             in_rs1,
  input  logic [4:0]             in_rs2,
  input  logic [31:0]            in_imm,
  input  logic                   in_last,
  output logic                   imem_we,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  output logic [31:0]            imem_wdata,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [1:0]             err_code,
  output logic [IMEM_ADDR_W:0]   count,
  output writer_state_t          dbg_state
);

  // Handshake: a word transfers on any rising edge where in_valid and in_ready are
  // both high; in_ready is high only while loading and start is low.

  localparam logic [IMEM_ADDR_W:0]   CAPACITY  = (IMEM_ADDR_W+1)'((1 << IMEM_ADDR_W) - BASE_ADDR);
  localparam logic [IMEM_ADDR_W-1:0] BASE_WORD = IMEM_ADDR_W'(BASE_ADDR);

  writer_state_t         state;
  rv32_err_code_t        err_code_q;
  rv32_err_code_t        chk_code;
  logic [IMEM_ADDR_W-1:0] ptr;
  logic [31:0]           enc_word;
  logic                  enc_legal;
  logic                  enc_imm_ok;

  rv32_instr_encoder u_encoder (
    .opcode (in_opcode),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .imm    (in_imm),
    .word   (enc_word),
    .legal  (enc_legal),
    .imm_ok (enc_imm_ok)
  );

  // Check order matters: an unknown opcode outranks a full memory, which outranks a bad immediate.
  always_comb begin
    chk_code = ERR_NONE;
    if (!enc_legal)               chk_code = ERR_UNKNOWN;
    else if (count >= CAPACITY)   chk_code = ERR_FULL;
    else if (!enc_imm_ok)         chk_code = ERR_IMM_RANGE;
  end

  assign in_ready  = (state == WR_LOAD) && !start;
  assign busy      = (state == WR_LOAD);
  assign done      = (state == WR_DONE);
  assign err       = (state == WR_ERROR);
  assign err_code  = err_code_q;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WR_IDLE;
      err_code_q <= ERR_NONE;
      ptr        <= '0;
      count      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= 1'b0;
      if (start) begin
        state      <= WR_LOAD;
        err_code_q <= ERR_NONE;
        ptr        <= BASE_WORD;
        count      <= '0;
      end else if (in_ready && in_valid) begin
        if (chk_code != ERR_NONE) begin
          state      <= WR_ERROR;
          err_code_q <= chk_code;
        end else begin
          imem_we    <= 1'b1;
          imem_addr  <= ptr;
          imem_wdata <= enc_word;
          ptr        <= ptr + 1'b1;
          count      <= count + 1'b1;
          if (in_last) state <= WR_DONE;
        end
      end
    end
  end

endmodule
